// File: rtl/wb_port_arbiter.sv
// Two-source arbiter feeding one registered valid/ready output slot.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to source 1.
module wb_port_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req1,
  input  logic [WIDTH-1:0] DataIn1,
  output logic             Ack1,
  input  logic             Req2,
  input  logic [WIDTH-1:0] DataIn2,
  output logic             Ack2,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] DataOut,
  output logic             Select
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dataOut_q, dataOut_d;
  logic             select_q, select_d;
  logic             captureSlot;
  logic             grant2;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // lastGrant_q = 1 means source 2 won the most recent capture.
  logic lastGrant_q, lastGrant_d;

  assign grant2 = Req2 & (~Req1 | ~lastGrant_q);

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (Ack2) begin
      lastGrant_d = 1'b1;
    end else if (Ack1) begin
      lastGrant_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lastGrant_q <= 1'b1;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end
`else
  assign grant2 = Req2 & ~Req1;
`endif

  // Acks are gated by Reset so nothing is acknowledged while the block is held in reset.
  always_comb begin
    state_d     = state_q;
    dataOut_d   = dataOut_q;
    select_d    = select_q;
    Ack1        = 1'b0;
    Ack2        = 1'b0;
    captureSlot = (state_q == IDLE) | OutReady;
    if (captureSlot && !Reset) begin
      if (Req1 || Req2) begin
        state_d = HOLD;
        if (grant2) begin
          dataOut_d = DataIn2;
          select_d  = 1'b1;
          Ack2      = 1'b1;
        end else begin
          dataOut_d = DataIn1;
          select_d  = 1'b0;
          Ack1      = 1'b1;
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      dataOut_q <= '0;
      select_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dataOut_q <= dataOut_d;
      select_q  <= select_d;
    end
  end

  assign OutValid = (state_q == HOLD);
  assign DataOut  = dataOut_q;
  assign Select   = select_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the data width of both sources and the output.
REQ-002 The module SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port Req1, input, 1 bit: source 1 requests transfer of DataIn1.
REQ-005 The module SHALL have port DataIn1, input, WIDTH bits: source 1 data, stable while Req1 is high.
REQ-006 The module SHALL have port Ack1, output, 1 bit: one-cycle pulse when DataIn1 is captured.
REQ-007 The module SHALL have port Req2, input, 1 bit: source 2 requests transfer of DataIn2.
REQ-008 The module SHALL have port DataIn2, input, WIDTH bits: source 2 data, stable while Req2 is high.
REQ-009 The module SHALL have port Ack2, output, 1 bit: one-cycle pulse when DataIn2 is captured.
REQ-010 The module SHALL have port OutValid, output, 1 bit: DataOut holds a transfer not yet accepted.
REQ-011 The module SHALL have port OutReady, input, 1 bit: the consumer accepts DataOut this cycle.
REQ-012 The module SHALL have port DataOut, output, WIDTH bits: the registered selected data.
REQ-013 The module SHALL have port Select, output, 1 bit: source of the held data, 0 = source 1, 1 = source 2.

Function
REQ-014 The block SHALL implement two states: IDLE (OutValid=0) and HOLD (OutValid=1).
REQ-015 A capture slot SHALL exist in a cycle when the state is IDLE, or when the state is HOLD and OutReady=1.
REQ-016 In a capture slot with at least one Req high, the block SHALL capture the winner's data into DataOut, set Select to the winner, and pulse the winner's Ack for that cycle.
REQ-017 Data captured in a cycle SHALL be visible on DataOut with OutValid=1 from the next rising edge, giving one cycle of latency.
REQ-018 In a capture slot with only one Req high, that source SHALL win.
REQ-019 Contention in a capture slot SHALL be resolved per REQ-030/REQ-031.
REQ-020 In a capture slot with no Req high, the block SHALL enter or remain in IDLE, with OutValid=0 on the next edge.
REQ-021 In HOLD with OutReady=0, DataOut, Select and OutValid SHALL hold stable, and no Ack SHALL assert.
REQ-022 In HOLD with OutReady=1 and a pending Req, the block SHALL capture back-to-back and stay in HOLD, sustaining one transfer per cycle.
REQ-023 At most one Ack SHALL assert per cycle.
REQ-024 Ack1 and Ack2 SHALL be combinational from state, Req and OutReady, with no registered delay.
REQ-025 A source SHALL keep Req high until its Ack, and deassertion before Ack SHALL withdraw the request without error.
REQ-026 DataOut SHALL change only in a capture slot with a winner.

Reset
REQ-027 Assertion of Reset SHALL immediately force state=IDLE, OutValid=0, DataOut=0, Select=0, Ack1=0, Ack2=0 and LastGrant=source 2, regardless of Clk.
REQ-028 Reset asserted mid-HOLD SHALL discard the held transfer with no Ack or replay afterwards.
REQ-029 The first capture slot SHALL occur on the first rising edge after Reset deasserts.

Configuration
REQ-030 With macro WB_ARB_ROUND_ROBIN_EN defined, contention SHALL be granted to the source other than LastGrant, and LastGrant SHALL update on every capture.
REQ-031 Without WB_ARB_ROUND_ROBIN_EN, contention SHALL always be granted to source 1 (fixed priority), and the LastGrant register SHALL not be implemented.

Verification
REQ-032 Single source: Req1=1 with DataIn1=0xDEADBEEF, OutReady=1 -> Ack1 pulses in cycle 0; DataOut=0xDEADBEEF, Select=0, OutValid=1 in cycle 1.
REQ-033 Backpressure: capture 0x11111111 from source 2, OutReady=0 for 3 cycles -> DataOut and Select=1 stable, no Ack; OutReady=1 -> next pending request captured in the same cycle.
REQ-034 Contention with macro: Req1=Req2=1 held for 4 slots, OutReady=1 -> grants alternate 1,2,1,2, one Ack per cycle.
REQ-035 Contention without macro: same stimulus as REQ-034 -> Ack1 every slot and Ack2 never asserts while Req1 is high.
REQ-036 Reset mid-HOLD: Reset pulse with OutValid=1 and DataOut=0xCAFEF00D -> OutValid=0 and DataOut=0 immediately; first grant after release follows the reset LastGrant value.
REQ-037 Idle drain: after the last accept with Req1=Req2=0 -> OutValid=0 on the next edge and DataOut holds its last value.
